// File: rtl/mips_cache_pkg.sv
// Shared constants and state encoding for the instruction-cache refill path.
package mips_cache_pkg;
  localparam int BLOCK_WORDS = 4;
  localparam int BLOCK_BITS  = 32 * BLOCK_WORDS;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/instr_block_refill.sv
// Critical-word-first block refill: reads one cache block word by word from
// main memory, wrapping inside the block, and hands it to the cache in one pulse.
module instr_block_refill
  import mips_cache_pkg::*;
#(
  parameter int WORDS  = BLOCK_WORDS,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req,
  input  logic [ADDR_W-1:0]   miss_addr,
  input  logic                flush,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [31:0]         mem_data,
  input  logic                mem_ack,
  output logic [32*WORDS-1:0] block_out,
  output logic [ADDR_W-1:0]   block_addr,
  output logic                block_valid,
  output logic                busy
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(4 * WORDS - 1);

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q;
  logic [IDX_W-1:0]   idx_q, cnt_q, idx_nxt, miss_idx;
  logic [ADDR_W-1:0]  miss_base;
  logic               accept, take, last, abort;

  // Only the word-index bits vary; the base (tag + index) never carries.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base | (ADDR_W'(idx) << 2);
  endfunction

  assign miss_base = miss_addr & ~OFF_MASK;
  assign miss_idx  = IDX_W'(miss_addr >> 2);
  assign idx_nxt   = (idx_q == IDX_W'(WORDS - 1)) ? '0 : idx_q + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = FETCH;
      FETCH:   if (abort) state_d = IDLE;
               else if (last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Flush beats a same-cycle ack, so a flushed word never reaches a lane.
  always_comb begin
    accept = (state_q == IDLE) && miss_req && !flush;
    abort  = (state_q == FETCH) && flush;
    take   = (state_q == FETCH) && mem_ack && !flush;
    last   = take && (cnt_q == IDX_W'(WORDS - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q      <= '0;
      idx_q       <= '0;
      cnt_q       <= '0;
      mem_rd      <= 1'b0;
      mem_addr    <= '0;
      block_addr  <= '0;
      block_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      block_valid <= 1'b0;
      if (accept) begin
        base_q   <= miss_base;
        idx_q    <= miss_idx;
        cnt_q    <= '0;
        mem_rd   <= 1'b1;
        mem_addr <= word_addr(miss_base, miss_idx);
        busy     <= 1'b1;
      end else if (abort) begin
        mem_rd <= 1'b0;
        busy   <= 1'b0;
      end else if (take) begin
        idx_q    <= idx_nxt;
        cnt_q    <= cnt_q + 1'b1;
        mem_addr <= word_addr(base_q, idx_nxt);
        if (last) begin
          mem_rd      <= 1'b0;
          block_valid <= 1'b1;
          block_addr  <= base_q;
        end
      end else if (state_q == DONE) begin
        busy <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < WORDS; k++) begin : g_lane
    logic        lane_we;
    logic [31:0] lane_q;
    assign lane_we = take && (idx_q == IDX_W'(k));
    always_ff @(posedge clk or negedge rst) begin
      if (!rst)         lane_q <= '0;
      else if (lane_we) lane_q <= mem_data;
    end
    assign block_out[32*k +: 32] = lane_q;
  end
endmodule

// File: tb/tb_instr_block_refill.sv
// Bench for instr_block_refill: directed table, corner sequences and random refills
// against an address/data model of critical-word-first block fetch.
module tb_instr_block_refill;
  logic         clk = 1'b0;
  logic         rst;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         flush;
  logic         mem_rd;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_data;
  logic         mem_ack;
  logic [127:0] block_out;
  logic [31:0]  block_addr;
  logic         block_valid;
  logic         busy;

  int n_tests = 0;
  int n_fail  = 0;

  instr_block_refill #(.WORDS(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr), .flush(flush),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
    .block_out(block_out), .block_addr(block_addr), .block_valid(block_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      addr;
    int               lat;
    int               flush_at;
    bit               toggle;
    logic [31:0]      base;
    logic [3:0][31:0] ea;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mkv(input logic [31:0] addr, input int lat, input int fa, input bit tg,
                               input logic [31:0] base, input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] a2, input logic [31:0] a3);
    vec_t v;
    v.addr = addr; v.lat = lat; v.flush_at = fa; v.toggle = tg; v.base = base;
    v.ea[0] = a0; v.ea[1] = a1; v.ea[2] = a2; v.ea[3] = a3;
    return v;
  endfunction

  // Reference model: the i-th word fetched starts at the missed word and wraps in the 16-byte block.
  function automatic logic [31:0] model_addr(input logic [31:0] addr, input int i);
    logic [31:0] base;
    int          w;
    base = addr & 32'hFFFF_FFF0;
    w    = (int'(addr[3:2]) + i) % 4;
    return base + 32'(4 * w);
  endfunction

  function automatic logic [127:0] model_block(input logic [31:0] base, input logic [31:0] salt);
    logic [127:0] b;
    for (int k = 0; k < 4; k++) b[32*k +: 32] = (base + 32'(4 * k)) ^ salt;
    return b;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_refill(input logic [31:0] addr, input int lat, input int flush_at, input bit toggle,
                           input logic [31:0] base, input logic [3:0][31:0] ea,
                           input logic [31:0] salt, input string tag);
    int acks = 0, wt = 0, pulses = 0, vcyc = -1, fcyc = -1, budget;
    bit flushed = 0;
    chk({tag, "/idle_busy"}, 128'(busy), 128'(0));
    miss_req = 1'b1; miss_addr = addr; flush = 1'b0; mem_ack = 1'b0;
    tick();
    budget = 4 * (lat + 1) + 4;
    for (int c = 1; c <= budget; c++) begin
      mem_ack = 1'b0; flush = 1'b0;
      if (vcyc >= 0 && c == vcyc + 1) begin
        chk({tag, "/valid_one_cycle"}, 128'(block_valid), 128'(0));
        chk({tag, "/busy_after_done"}, 128'(busy), 128'(0));
        break;
      end
      if (block_valid) begin
        pulses++;
        if (vcyc < 0) begin
          vcyc = c;
          chk({tag, "/block_out"}, block_out, model_block(base, salt));
          chk({tag, "/block_addr"}, 128'(block_addr), 128'(base));
          chk({tag, "/done_busy"}, 128'(busy), 128'(1));
          chk({tag, "/done_mem_rd"}, 128'(mem_rd), 128'(0));
        end
        miss_req = 1'b0;
      end
      if (toggle && c == 2) begin miss_req = 1'b0; miss_addr = 32'h40; end
      if (toggle && c == 3) miss_req = 1'b1;
      if (!flushed && mem_rd && acks < 4) begin
        chk($sformatf("%s/mem_addr%0d", tag, acks), 128'(mem_addr), 128'(ea[acks]));
        if (wt == lat) begin
          mem_ack = 1'b1; mem_data = mem_addr ^ salt; acks++; wt = 0;
          if (acks == flush_at) begin flush = 1'b1; flushed = 1'b1; fcyc = c; end
        end else wt++;
      end else if (flushed && c == fcyc + 1) begin
        chk({tag, "/flush_mem_rd"}, 128'(mem_rd), 128'(0));
        chk({tag, "/flush_busy"}, 128'(busy), 128'(0));
        miss_req = 1'b0; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
      end
      tick();
    end
    mem_ack = 1'b0; flush = 1'b0; miss_req = 1'b0;
    chk({tag, "/pulses"}, 128'(pulses), 128'((flush_at != 0) ? 0 : 1));
    if (flush_at == 0) chk({tag, "/latency"}, 128'(vcyc), 128'(4 * (lat + 1) + 1));
    else chk({tag, "/flush_acks"}, 128'(acks), 128'(flush_at));
  endtask

  initial begin
    int pulses;
    logic [31:0] a, s;
    logic [3:0][31:0] ea;
    rst = 1'b0; miss_req = 1'b0; miss_addr = '0; flush = 1'b0; mem_ack = 1'b0; mem_data = '0;
    tick(); tick();
    chk("rst/mem_rd", 128'(mem_rd), 128'(0));
    chk("rst/mem_addr", 128'(mem_addr), 128'(0));
    chk("rst/block_out", block_out, 128'(0));
    chk("rst/block_addr", 128'(block_addr), 128'(0));
    chk("rst/block_valid", 128'(block_valid), 128'(0));
    chk("rst/busy", 128'(busy), 128'(0));
    @(negedge clk); rst = 1'b1;
    tick();

    // Reset in the middle of a refill, after two words have landed.
    miss_req = 1'b1; miss_addr = 32'h20;
    tick();
    for (int i = 0; i < 2; i++) begin
      mem_ack = 1'b1; mem_data = mem_addr ^ 32'h1234_0000;
      tick();
    end
    mem_ack = 1'b0;
    chk("midrst/lanes_written", 128'(block_out != 0), 128'(1));
    #2 rst = 1'b0;
    #1;
    chk("midrst/mem_rd", 128'(mem_rd), 128'(0));
    chk("midrst/mem_addr", 128'(mem_addr), 128'(0));
    chk("midrst/block_out", block_out, 128'(0));
    chk("midrst/block_valid", 128'(block_valid), 128'(0));
    chk("midrst/busy", 128'(busy), 128'(0));
    @(negedge clk); rst = 1'b1; miss_req = 1'b0;
    tick();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      mem_ack = 1'b1; mem_data = 32'hFFFF_FFFF;
      if (block_valid || mem_rd) pulses++;
      tick();
    end
    mem_ack = 1'b0;
    chk("midrst/late_acks_ignored", 128'(pulses), 128'(0));
    chk("midrst/block_out_kept", block_out, 128'(0));

    vt.push_back(mkv(32'h0000_0000, 0, 0, 0, 32'h0000_0000, 32'h0, 32'h4, 32'h8, 32'hC));
    vt.push_back(mkv(32'h0000_0008, 2, 0, 0, 32'h0000_0000, 32'h8, 32'hC, 32'h0, 32'h4));
    vt.push_back(mkv(32'hFFFF_FFFC, 0, 0, 0, 32'hFFFF_FFF0,
                     32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFF4, 32'hFFFF_FFF8));
    vt.push_back(mkv(32'h0000_0000, 0, 2, 0, 32'h0000_0000, 32'h0, 32'h4, 32'h8, 32'hC));
    vt.push_back(mkv(32'h0000_0010, 0, 0, 0, 32'h0000_0010, 32'h10, 32'h14, 32'h18, 32'h1C));
    vt.push_back(mkv(32'h0000_0000, 1, 0, 1, 32'h0000_0000, 32'h0, 32'h4, 32'h8, 32'hC));
    vt.push_back(mkv(32'h0000_0040, 0, 0, 0, 32'h0000_0040, 32'h40, 32'h44, 32'h48, 32'h4C));
    vt.push_back(mkv(32'h0000_0106, 1, 0, 0, 32'h0000_0100, 32'h104, 32'h108, 32'h10C, 32'h100));
    vt.push_back(mkv(32'h0000_0204, 0, 4, 0, 32'h0000_0200, 32'h204, 32'h208, 32'h20C, 32'h200));
    foreach (vt[i])
      do_refill(vt[i].addr, vt[i].lat, vt[i].flush_at, vt[i].toggle, vt[i].base, vt[i].ea,
                32'hA5A5_0000, $sformatf("vec%0d", i));

    for (int r = 0; r < 25; r++) begin
      a = $urandom;
      s = $urandom;
      for (int i = 0; i < 4; i++) ea[i] = model_addr(a, i);
      do_refill(a, int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                1'b0, a & 32'hFFFF_FFF0, ea, s, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
